// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the DMEM port-B arbiter and its priority selector.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_NONE = 4'b0000;

    // Read latency counter covers READ_LAT-1 for READ_LAT in 1..4.
    localparam int LAT_W = 2;

    // DBG starvation counter saturates instead of wrapping.
    localparam int         WAIT_W   = 8;
    localparam logic [7:0] WAIT_SAT = 8'hFF;

endpackage

// File: rtl/dmem_arb_prio.sv
// dmem_arb_prio: combinational winner selection for the DMEM port-B arbiter.
// rr_mode=0: fixed CPU priority, DBG wins a tie once wait_cnt reaches MAX_WAIT.
// rr_mode=1: a tie goes to the requester that did not win last (last_win).
module dmem_arb_prio
    import dmem_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic              cpu_req,
    input  logic              dbg_req,
    input  logic [WAIT_W-1:0] wait_cnt,
    input  owner_t            last_win,
    input  logic              rr_mode,
    output owner_t            win_sel,
    output logic              win_valid
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    // Pick the winner among the active requesters.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        win_valid = cpu_req | dbg_req;
        win_sel   = OWN_CPU;
        if (dbg_req && !cpu_req) begin
            win_sel = OWN_DBG;
        end else if (cpu_req && dbg_req) begin
            if (rr_mode) begin
                win_sel = (last_win == OWN_CPU) ? OWN_DBG : OWN_CPU;
            end else if (wait_cnt >= MAX_WAIT_C) begin
                win_sel = OWN_DBG;
            end
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares DMEM BRAM port B between the CPU load/store unit
// and the debug/program loader. Writes complete in their grant cycle; a read
// holds the port for READ_LAT cycles and returns the raw word with an rvalid pulse.
// Build option DMEM_ARB_RR_EN: alternate priority on contention instead of
// fixed CPU priority with the MAX_WAIT starvation override.
module dmem_port_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int READ_LAT = 1,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [3:0]        cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic [3:0]        dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [31:0]       dbg_rdata,
    output logic              enb,
    output logic [3:0]        web,
    output logic [ADDR_W-1:0] addrb,
    output logic [31:0]       dib,
    input  logic [31:0]       dob
);

    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(READ_LAT - 1);

    state_t            state, state_nxt;
    owner_t            owner, owner_nxt;
    logic [LAT_W-1:0]  lat_cnt, lat_nxt;
    logic              rsp_fire;
    owner_t            win_sel;
    logic              win_valid;
    logic [WAIT_W-1:0] prio_wait;
    owner_t            prio_last;
    logic              prio_rr;

    dmem_arb_prio #(
        .MAX_WAIT (MAX_WAIT)
    ) u_prio (
        .cpu_req   (cpu_req),
        .dbg_req   (dbg_req),
        .wait_cnt  (prio_wait),
        .last_win  (prio_last),
        .rr_mode   (prio_rr),
        .win_sel   (win_sel),
        .win_valid (win_valid)
    );

`ifdef DMEM_ARB_RR_EN
    owner_t last_win;

    assign prio_wait = '0;
    assign prio_last = last_win;
    assign prio_rr   = 1'b1;

    // Remember who won the most recent grant so the next tie goes the other way.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_win <= OWN_DBG;
        end else if (cpu_gnt || dbg_gnt) begin
            last_win <= cpu_gnt ? OWN_CPU : OWN_DBG;
        end
    end
`else
    logic [WAIT_W-1:0] wait_cnt;

    assign prio_wait = wait_cnt;
    assign prio_last = OWN_DBG;
    assign prio_rr   = 1'b0;

    // Count consecutive cycles DBG is refused; saturate at WAIT_SAT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!dbg_req || dbg_gnt) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_SAT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`endif

    // Grant, port muxing and next-state decode.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        lat_nxt   = lat_cnt;
        rsp_fire  = 1'b0;
        cpu_gnt   = 1'b0;
        dbg_gnt   = 1'b0;
        enb       = 1'b0;
        web       = BE_NONE;
        addrb     = '0;
        dib       = '0;
        case (state)
            ST_IDLE: begin
                // Grants are held off while reset is asserted.
                if (win_valid && !rst) begin
                    enb = 1'b1;
                    if (win_sel == OWN_CPU) begin
                        cpu_gnt = 1'b1;
                        web     = cpu_we;
                        addrb   = cpu_addr;
                        dib     = cpu_wdata;
                    end else begin
                        dbg_gnt = 1'b1;
                        web     = dbg_we;
                        addrb   = dbg_addr;
                        dib     = dbg_wdata;
                    end
                    if (web == BE_NONE) begin
                        owner_nxt = win_sel;
                        lat_nxt   = LAT_INIT;
                        state_nxt = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (lat_cnt == '0) begin
                    rsp_fire  = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    lat_nxt = lat_cnt - 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, read owner and latency counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            owner   <= OWN_CPU;
            lat_cnt <= '0;
        end else begin
            // NOTE: non-blocking so every register here samples pre-edge values.
            state   <= state_nxt;
            owner   <= owner_nxt;
            lat_cnt <= lat_nxt;
        end
    end

    // Capture dob into the owner's rdata and pulse its rvalid; the other side holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
        end else begin
            cpu_rvalid <= rsp_fire && (owner == OWN_CPU);
            dbg_rvalid <= rsp_fire && (owner == OWN_DBG);
            if (rsp_fire && (owner == OWN_CPU)) begin
                cpu_rdata <= dob;
            end
            if (rsp_fire && (owner == OWN_DBG)) begin
                dbg_rdata <= dob;
            end
        end
    end

    // CPU stalls while refused, and from its read grant until the cycle before rvalid.
    assign cpu_stall = (cpu_req && !cpu_gnt)
                     || (cpu_gnt && (cpu_we == BE_NONE))
                     || ((state == ST_RD_WAIT) && (owner == OWN_CPU));

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed and randomized check of dmem_port_arbiter
// against a transaction-level reference model (shadow memory, pending-read
// queue, "port free at cycle" bookkeeping) and a behavioural BRAM.
module tb_dmem_port_arbiter;

    localparam int ADDR_W    = 32;
    localparam int RL        = 3;
    localparam int MW        = 3;
    localparam int MEM_WORDS = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cpu_req = 1'b0, dbg_req = 1'b0;
    logic [3:0]        cpu_we = '0, dbg_we = '0;
    logic [ADDR_W-1:0] cpu_addr = '0, dbg_addr = '0;
    logic [31:0]       cpu_wdata = '0, dbg_wdata = '0;
    logic              cpu_gnt, cpu_rvalid, cpu_stall, dbg_gnt, dbg_rvalid, enb;
    logic [31:0]       cpu_rdata, dbg_rdata, dib, dob;
    logic [3:0]        web;
    logic [ADDR_W-1:0] addrb;

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .READ_LAT (RL),
        .MAX_WAIT (MW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .enb        (enb),
        .web        (web),
        .addrb      (addrb),
        .dib        (dib),
        .dob        (dob)
    );

    // Behavioural BRAM: byte-lane writes, read data appears RL cycles after enb;
    // junk is shifted in on non-read cycles so a mistimed capture shows up.
    logic [31:0] bram     [MEM_WORDS];
    logic [31:0] dob_pipe [RL];
    assign dob = dob_pipe[RL-1];

    always @(posedge clk) begin
        if (enb && web != 4'b0000) begin
            for (int b = 0; b < 4; b++) begin
                if (web[b]) bram[addrb[5:2]][8*b +: 8] <= dib[8*b +: 8];
            end
        end
        dob_pipe[0] <= (enb && web == 4'b0000) ? bram[addrb[5:2]] : $urandom;
        for (int i = 1; i < RL; i++) dob_pipe[i] <= dob_pipe[i-1];
    end

    // Reference model state.
    typedef struct {
        int          due;
        bit          who;   // 1 = DBG
        logic [31:0] data;
    } rsp_t;

    rsp_t        pend[$];
    logic [31:0] shadow [MEM_WORDS];
    int          cyc, free_at, m_wait;
    bit          m_last_dbg;
    bit          m_gc, m_gd;
    logic [31:0] m_cpu_rdata, m_dbg_rdata;
    logic        o_cg, o_dg, o_crv, o_drv;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] rand_we();
        case ($urandom_range(0, 4))
            0, 1:    return 4'b0000;
            2:       return 4'b1111;
            3:       return 4'b0001 << $urandom_range(0, 3);
            default: return ($urandom_range(0, 1) != 0) ? 4'b0011 : 4'b1100;
        endcase
    endfunction

    function automatic logic [31:0] rand_addr();
        return {26'd0, 4'($urandom_range(0, MEM_WORDS - 1)), 2'b00};
    endfunction

    // One clock cycle: predict, compare at negedge, advance the model, step past posedge.
    task automatic cycle();
        rsp_t        rsp;
        logic        e_enb, e_crv, e_drv, e_stall, win_dbg;
        logic [3:0]  e_web;
        logic [31:0] e_addr, e_dib;
        int          idx;
        @(negedge clk);
        e_crv = 1'b0;
        e_drv = 1'b0;
        if (pend.size() != 0 && pend[0].due == cyc) begin
            rsp = pend.pop_front();
            if (rsp.who) begin e_drv = 1'b1; m_dbg_rdata = rsp.data; end
            else         begin e_crv = 1'b1; m_cpu_rdata = rsp.data; end
        end
        m_gc = 0; m_gd = 0; win_dbg = 1'b0;
        e_web = '0; e_addr = '0; e_dib = '0;
        if (cyc >= free_at && (cpu_req || dbg_req)) begin
            if (cpu_req && dbg_req) begin
`ifdef DMEM_ARB_RR_EN
                win_dbg = !m_last_dbg;
`else
                win_dbg = (m_wait >= MW);
`endif
            end else begin
                win_dbg = dbg_req;
            end
            m_gc   = !win_dbg;
            m_gd   = win_dbg;
            e_web  = win_dbg ? dbg_we    : cpu_we;
            e_addr = win_dbg ? dbg_addr  : cpu_addr;
            e_dib  = win_dbg ? dbg_wdata : cpu_wdata;
            idx    = int'(e_addr[5:2]);
            if (e_web == 4'b0000) begin
                pend.push_back('{due: cyc + RL + 1, who: win_dbg, data: shadow[idx]});
                free_at = cyc + RL + 1;
            end else begin
                for (int b = 0; b < 4; b++)
                    if (e_web[b]) shadow[idx][8*b +: 8] = e_dib[8*b +: 8];
            end
        end
        e_enb   = m_gc | m_gd;
        e_stall = (cpu_req && !m_gc) || (pend.size() != 0 && !pend[0].who);

        o_cg = cpu_gnt; o_dg = dbg_gnt; o_crv = cpu_rvalid; o_drv = dbg_rvalid;
        check("cpu_gnt",    32'(cpu_gnt),    32'(m_gc));
        check("dbg_gnt",    32'(dbg_gnt),    32'(m_gd));
        check("enb",        32'(enb),        32'(e_enb));
        check("web",        32'(web),        32'(e_web));
        if (e_enb) begin
            check("addrb", addrb, e_addr);
            check("dib",   dib,   e_dib);
        end
        check("cpu_rvalid", 32'(cpu_rvalid), 32'(e_crv));
        check("dbg_rvalid", 32'(dbg_rvalid), 32'(e_drv));
        check("cpu_rdata",  cpu_rdata,       m_cpu_rdata);
        check("dbg_rdata",  dbg_rdata,       m_dbg_rdata);
        check("cpu_stall",  32'(cpu_stall),  32'(e_stall));

        if (dbg_req && !m_gd) m_wait = (m_wait < 255) ? m_wait + 1 : 255;
        else                  m_wait = 0;
        if (m_gc || m_gd) m_last_dbg = m_gd;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Hold rst for n cycles, checking the reset-state outputs, then release.
    task automatic apply_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("rst_cpu_gnt",    32'(cpu_gnt),    32'd0);
            check("rst_dbg_gnt",    32'(dbg_gnt),    32'd0);
            check("rst_enb",        32'(enb),        32'd0);
            check("rst_web",        32'(web),        32'd0);
            check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
            check("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
            check("rst_cpu_rdata",  cpu_rdata,       32'd0);
            check("rst_dbg_rdata",  dbg_rdata,       32'd0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        pend.delete();
        cyc = 0; free_at = 0; m_wait = 0; m_last_dbg = 1'b1;
        m_gc = 0; m_gd = 0;
        m_cpu_rdata = '0; m_dbg_rdata = '0;
    endtask

    initial begin
        logic [7:0] pat;
        int         t_dg, t_crv, t_drv;

        for (int i = 0; i < MEM_WORDS; i++) shadow[i] = '0;
        apply_reset(2);

        // Program loader fills memory; word 8 (0x20) gets a known pattern.
        for (int i = 0; i < MEM_WORDS; i++) begin
            dbg_req = 1'b1; dbg_we = 4'b1111; dbg_addr = 32'(i * 4);
            dbg_wdata = (i == 8) ? 32'hDEAD_BEEF : $urandom;
            cycle();
        end
        dbg_req = 1'b0;
        cycle();

        // Single-lane CPU write, then another write the very next cycle.
        cpu_req = 1'b1; cpu_we = 4'b0100; cpu_addr = 32'h10; cpu_wdata = 32'h00AB_0000;
        cycle();
        cpu_we = 4'b0001; cpu_addr = 32'h14; cpu_wdata = 32'h0000_0055;
        cycle();
        cpu_req = 1'b0;
        cycle();

        // CPU read of the known word.
        cpu_req = 1'b1; cpu_we = 4'b0000; cpu_addr = 32'h20;
        cycle();
        cpu_req = 1'b0;
        for (int i = 0; i < RL + 2; i++) cycle();
        check("tp_read_word", cpu_rdata, 32'hDEAD_BEEF);

        // Contention: both sides stream writes.
        pat = '0;
        cpu_req = 1'b1; cpu_we = 4'b1111; cpu_addr = rand_addr(); cpu_wdata = $urandom;
        dbg_req = 1'b1; dbg_we = 4'b1111; dbg_addr = rand_addr(); dbg_wdata = $urandom;
        for (int i = 0; i < 8; i++) begin
            cycle();
            pat = {pat[6:0], o_cg};
            if (m_gc) begin cpu_addr = rand_addr(); cpu_wdata = $urandom; end
            if (m_gd) begin dbg_addr = rand_addr(); dbg_wdata = $urandom; end
        end
`ifdef DMEM_ARB_RR_EN
        check("tp_rr_alternate", 32'(pat == 8'hAA || pat == 8'h55), 32'd1);
`else
        check("tp_fixed_pattern", 32'(pat), 32'h0000_00EE);
`endif
        cpu_req = 1'b0; dbg_req = 1'b0;
        cycle();

        // Reset one cycle after a DBG read grant; a CPU read is waiting across it.
        dbg_req = 1'b1; dbg_we = 4'b0000; dbg_addr = 32'h20;
        cycle();
        dbg_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 4'b0000; cpu_addr = 32'h20;
        apply_reset(1);
        cycle();
        cpu_req = 1'b0;
        for (int i = 0; i < RL + 3; i++) cycle();

        // CPU read, DBG read queued behind it.
        t_dg = -100; t_crv = -200; t_drv = -300;
        cpu_req = 1'b1; cpu_we = 4'b0000; cpu_addr = rand_addr();
        for (int i = 0; i < 2 * RL + 6; i++) begin
            cycle();
            if (o_dg  && t_dg  < 0) t_dg  = cyc - 1;
            if (o_crv && t_crv < 0) t_crv = cyc - 1;
            if (o_drv && t_drv < 0) t_drv = cyc - 1;
            if (m_gc) cpu_req = 1'b0;
            if (m_gd) dbg_req = 1'b0;
            if (i == 0) begin dbg_req = 1'b1; dbg_we = 4'b0000; dbg_addr = rand_addr(); end
        end
        check("tp_rr_gnt_at_rvalid", 32'(t_dg),        32'(t_crv));
        check("tp_rr_dbg_latency",   32'(t_drv - t_dg), 32'(RL + 1));

        // Randomized traffic with requests held until granted.
        for (int i = 0; i < 2500; i++) begin
            if (i == 1200) apply_reset(1);
            if (!cpu_req || m_gc) begin
                cpu_req = ($urandom_range(0, 3) != 0);
                cpu_we = rand_we(); cpu_addr = rand_addr(); cpu_wdata = $urandom;
            end
            if (!dbg_req || m_gd) begin
                dbg_req = ($urandom_range(0, 2) != 0);
                dbg_we = rand_we(); dbg_addr = rand_addr(); dbg_wdata = $urandom;
            end
            cycle();
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        for (int i = 0; i < RL + 2; i++) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
